// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: one-block SHA-256 compression engine.
// A block is accepted in IDLE, compressed over 64 single-round edges in
// ROUND, then added to its seed in FINISH, which publishes the digest on
// 'hashed' with a one-cycle 'done' pulse.
// Optional feature macro: SHA256_CHAIN_EN. When defined, 'first' selects
// between the IV and the previous digest as the seed, and a chaining
// register carries the digest across blocks. When undefined, every block
// is seeded from the IV and 'first' is ignored.
module sha256_round_ctrl #(
   parameter int PADDED_SIZE = 512
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   first,
   input  logic [PADDED_SIZE-1:0] block,
   output logic                   busy,
   output logic                   done,
   output logic [255:0]           hashed
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROUND  = 2'd1,
      FINISH = 2'd2
   } state_t;

   // Initial hash value H0..H7, H0 in the top word.
   localparam logic [255:0] IV_PACKED = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   // Round constants, indexed directly by the 6-bit round counter.
   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // ------------------------------------------------------------------
   // SHA-256 primitive functions
   // ------------------------------------------------------------------
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t        state_reg;
   state_t        state_next;
   logic [5:0]    cnt_reg;
   logic [31:0]   work_reg [0:7];   // a..h
   logic [31:0]   w_reg    [0:15];  // message schedule window, slot 0 = W[cnt]
   logic          done_reg;
   logic [255:0]  hashed_reg;

   // Phase decodes shared by the datapath processes.
   logic          load;
   logic          round;
   logic          finish;

   // Round arithmetic.
   logic [31:0]   t1;
   logic [31:0]   t2;
   logic [31:0]   w_new;

   // Seeds: load_seed is used when a block is accepted, fin_seed when the
   // compressed state is folded back in. Both are the same words, but the
   // selection inputs differ in time (live 'first' vs the latched copy).
   logic [255:0]  load_seed;
   logic [255:0]  fin_seed;
   logic [255:0]  digest;

   assign load   = (state_reg == IDLE) && start;
   assign round  = (state_reg == ROUND);
   assign finish = (state_reg == FINISH);

`ifdef SHA256_CHAIN_EN
   logic [255:0]  chain_reg;
   logic          first_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_seed
         assign load_seed[255-32*gi -: 32] = first ? IV_PACKED[255-32*gi -: 32]
                                                   : chain_reg[255-32*gi -: 32];
         assign fin_seed[255-32*gi -: 32]  = first_reg ? IV_PACKED[255-32*gi -: 32]
                                                       : chain_reg[255-32*gi -: 32];
      end
   endgenerate

   // Chaining register and the latched seed selector for the running block.
   always_ff @(posedge clk) begin
      if (reset) begin
         chain_reg <= IV_PACKED;
         first_reg <= 1'b1;
      end else begin
         if (load) begin
            first_reg <= first;
         end
         if (finish) begin
            chain_reg <= digest;
         end
      end
   end
`else
   logic unused_first;
   assign unused_first = first;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_seed
         assign load_seed[255-32*gi -: 32] = IV_PACKED[255-32*gi -: 32];
         assign fin_seed[255-32*gi -: 32]  = IV_PACKED[255-32*gi -: 32];
      end
   endgenerate
`endif

   // Final feed-forward: each digest word is seed word plus working word.
   generate
      for (gi = 0; gi < 8; gi++) begin : g_digest
         assign digest[255-32*gi -: 32] = fin_seed[255-32*gi -: 32] + work_reg[gi];
      end
   endgenerate

   // One compression round and the next schedule word, all mod 2^32.
   always_comb begin
      t1 = work_reg[7] + big_sigma1(work_reg[4])
         + ch(work_reg[4], work_reg[5], work_reg[6])
         + K[cnt_reg] + w_reg[0];
      t2 = big_sigma0(work_reg[0]) + maj(work_reg[0], work_reg[1], work_reg[2]);
      w_new = small_sigma1(w_reg[14]) + w_reg[9] + small_sigma0(w_reg[1]) + w_reg[0];
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: round 63 hands over to FINISH, FINISH always returns.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = ROUND;
         ROUND:   if (cnt_reg == 6'd63) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode: busy covers ROUND and FINISH, the rest are registers.
   always_comb begin
      busy   = (state_reg != IDLE);
      done   = done_reg;
      hashed = hashed_reg;
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------

   // Round counter: cleared on acceptance, naturally wraps 63 -> 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg <= 6'd0;
      end else if (load) begin
         cnt_reg <= 6'd0;
      end else if (round) begin
         cnt_reg <= cnt_reg + 6'd1;
      end
   end

   // Working variables a..h: seeded on acceptance, rotated every round.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            work_reg[i] <= '0;
         end
      end else if (load) begin
         for (int i = 0; i < 8; i++) begin
            work_reg[i] <= load_seed[255-32*i -: 32];
         end
      end else if (round) begin
         work_reg[0] <= t1 + t2;
         work_reg[1] <= work_reg[0];
         work_reg[2] <= work_reg[1];
         work_reg[3] <= work_reg[2];
         work_reg[4] <= work_reg[3] + t1;
         work_reg[5] <= work_reg[4];
         work_reg[6] <= work_reg[5];
         work_reg[7] <= work_reg[6];
      end
   end

   // Schedule window: loaded with M0..M15, then shifts down one word per
   // round while the freshly expanded word enters at slot 15.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            w_reg[i] <= '0;
         end
      end else if (load) begin
         for (int i = 0; i < 16; i++) begin
            w_reg[i] <= block[PADDED_SIZE-1-32*i -: 32];
         end
      end else if (round) begin
         for (int i = 0; i < 15; i++) begin
            w_reg[i] <= w_reg[i+1];
         end
         w_reg[15] <= w_new;
      end
   end

   // Digest publication and the single-cycle done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         done_reg   <= 1'b0;
         hashed_reg <= '0;
      end else begin
         done_reg <= finish;
         if (finish) begin
            hashed_reg <= digest;
         end
      end
   end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed testbench for sha256_round_ctrl using known SHA-256 vectors.
module tb_sha256_round_ctrl;

   logic         clk;
   logic         reset;
   logic         start;
   logic         first;
   logic [511:0] block;
   logic         busy;
   logic         done;
   logic [255:0] hashed;

   int tests;
   int fails;

   localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] BLK_TWO_1 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
   };
   localparam logic [511:0] BLK_TWO_2 = {480'h0, 32'h000001c0};

   localparam logic [255:0] DIG_ABC =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] DIG_EMPTY =
      256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] DIG_TWO =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   sha256_round_ctrl #(.PADDED_SIZE(512)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .first  (first),
      .block  (block),
      .busy   (busy),
      .done   (done),
      .hashed (hashed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one block and wait (bounded) for done; lat counts edges from the
   // accepting edge inclusive, so the nominal value is 66.
   task automatic run_block(input logic [511:0] blk, input logic fst,
                            output int lat, output logic [255:0] dig);
      int n;
      @(negedge clk);
      block = blk;
      first = fst;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      block = '0;
      first = ~fst;
      n = 1;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      lat = n;
      dig = hashed;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL reset_done: got %b expected 0", done);
      end
      tests++;
      if (hashed !== 256'h0) begin
         fails++;
         $display("FAIL reset_hashed: got %h expected 0", hashed);
      end
      reset = 1'b0;
      $display("[TB] reset: busy=%b done=%b hashed=%h", busy, done, hashed);
   endtask

   task automatic test_abc();
      int lat;
      logic [255:0] dig;
      run_block(BLK_ABC, 1'b1, lat, dig);
      $display("[TB] abc: latency=%0d hashed=%h", lat, dig);
      tests++;
      if (lat !== 66) begin
         fails++;
         $display("FAIL abc_latency: got %0d expected 66", lat);
      end
      tests++;
      if (dig !== DIG_ABC) begin
         fails++;
         $display("FAIL abc_digest: got %h expected %h", dig, DIG_ABC);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL abc_done_width: got %b expected 0", done);
      end
      tests++;
      if (hashed !== DIG_ABC) begin
         fails++;
         $display("FAIL abc_hold: got %h expected %h", hashed, DIG_ABC);
      end
   endtask

   task automatic test_empty();
      int lat;
      logic [255:0] dig;
      run_block(BLK_EMPTY, 1'b1, lat, dig);
      $display("[TB] empty: latency=%0d hashed=%h", lat, dig);
      tests++;
      if (lat !== 66) begin
         fails++;
         $display("FAIL empty_latency: got %0d expected 66", lat);
      end
      tests++;
      if (dig !== DIG_EMPTY) begin
         fails++;
         $display("FAIL empty_digest: got %h expected %h", dig, DIG_EMPTY);
      end
   endtask

   // After reset the chaining value is the IV, so first=0 still yields "abc".
   task automatic test_first_after_reset();
      int lat;
      logic [255:0] dig;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      run_block(BLK_ABC, 1'b0, lat, dig);
      $display("[TB] abc first=0 after reset: latency=%0d hashed=%h", lat, dig);
      tests++;
      if (dig !== DIG_ABC) begin
         fails++;
         $display("FAIL chain_iv_after_reset: got %h expected %h", dig, DIG_ABC);
      end
   endtask

`ifdef SHA256_CHAIN_EN
   task automatic test_chain();
      int lat;
      logic [255:0] dig;
      run_block(BLK_TWO_1, 1'b1, lat, dig);
      $display("[TB] two-block part 1: latency=%0d hashed=%h", lat, dig);
      run_block(BLK_TWO_2, 1'b0, lat, dig);
      $display("[TB] two-block part 2: latency=%0d hashed=%h", lat, dig);
      tests++;
      if (dig !== DIG_TWO) begin
         fails++;
         $display("FAIL two_block_digest: got %h expected %h", dig, DIG_TWO);
      end
   endtask
`else
   // Without chaining, first=0 after a different block still seeds from IV.
   task automatic test_first_ignored();
      int lat;
      logic [255:0] dig;
      run_block(BLK_EMPTY, 1'b1, lat, dig);
      run_block(BLK_ABC, 1'b0, lat, dig);
      $display("[TB] abc first=0 after empty: latency=%0d hashed=%h", lat, dig);
      tests++;
      if (dig !== DIG_ABC) begin
         fails++;
         $display("FAIL first_ignored: got %h expected %h", dig, DIG_ABC);
      end
   endtask
`endif

   // start held high throughout: two back-to-back blocks, 66 edges apart.
   task automatic test_back_to_back();
      int lat;
      int n;
      int ndone;
      int pos1;
      int pos2;
      int dbl;
      logic prev_done;
      logic [255:0] dig;
      logic [255:0] mid1;
      logic [255:0] mid2;
      run_block(BLK_ABC, 1'b1, lat, dig);
      @(negedge clk);
      block = BLK_EMPTY;
      first = 1'b1;
      start = 1'b1;
      @(posedge clk);
      ndone = 0;
      pos1 = 0;
      pos2 = 0;
      dbl = 0;
      prev_done = 1'b0;
      mid1 = '0;
      mid2 = '0;
      for (n = 1; n <= 140; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            if (ndone == 1) pos1 = n;
            if (ndone == 2) pos2 = n;
            if (prev_done === 1'b1) dbl++;
         end
         prev_done = done;
         if (n == 30) mid1 = hashed;
         if (n == 100) mid2 = hashed;
         if (n == 132) start = 1'b0;
      end
      $display("[TB] back_to_back: dones=%0d at %0d,%0d hashed=%h", ndone, pos1, pos2, hashed);
      tests++;
      if (ndone !== 2 || pos1 !== 66 || pos2 !== 132) begin
         fails++;
         $display("FAIL b2b_done_pos: got count=%0d pos=%0d,%0d expected 2 at 66,132",
                  ndone, pos1, pos2);
      end
      tests++;
      if (dbl !== 0) begin
         fails++;
         $display("FAIL b2b_double_done: got %0d expected 0", dbl);
      end
      tests++;
      if (mid1 !== DIG_ABC) begin
         fails++;
         $display("FAIL b2b_hold_mid1: got %h expected %h", mid1, DIG_ABC);
      end
      tests++;
      if (mid2 !== DIG_EMPTY) begin
         fails++;
         $display("FAIL b2b_hold_mid2: got %h expected %h", mid2, DIG_EMPTY);
      end
      tests++;
      if (hashed !== DIG_EMPTY || busy !== 1'b0) begin
         fails++;
         $display("FAIL b2b_final: got hashed=%h busy=%b expected %h busy=0",
                  hashed, busy, DIG_EMPTY);
      end
   endtask

   // Reset 30 edges into a block aborts it; a fresh block then works.
   task automatic test_reset_abort();
      int lat;
      int ndone;
      logic [255:0] dig;
      @(negedge clk);
      block = BLK_ABC;
      first = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      $display("[TB] reset_abort: busy=%b done=%b hashed=%h", busy, done, hashed);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || hashed !== 256'h0) begin
         fails++;
         $display("FAIL abort_state: got busy=%b done=%b hashed=%h expected 0 0 0",
                  busy, done, hashed);
      end
      ndone = 0;
      repeat (80) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      tests++;
      if (ndone !== 0 || hashed !== 256'h0) begin
         fails++;
         $display("FAIL abort_no_done: got dones=%0d hashed=%h expected 0 and 0", ndone, hashed);
      end
      run_block(BLK_ABC, 1'b1, lat, dig);
      $display("[TB] abc after abort: latency=%0d hashed=%h", lat, dig);
      tests++;
      if (dig !== DIG_ABC || lat !== 66) begin
         fails++;
         $display("FAIL abort_recover: got %h lat=%0d expected %h lat=66", dig, lat, DIG_ABC);
      end
   endtask

   // Reset wins over start on the same edge.
   task automatic test_reset_priority();
      int ndone;
      @(negedge clk);
      block = BLK_EMPTY;
      first = 1'b1;
      start = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      $display("[TB] reset_priority: busy=%b done=%b", busy, done);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL prio_idle: got busy=%b done=%b expected 0 0", busy, done);
      end
      ndone = 0;
      repeat (70) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      tests++;
      if (ndone !== 0 || hashed !== 256'h0) begin
         fails++;
         $display("FAIL prio_no_done: got dones=%0d hashed=%h expected 0 and 0", ndone, hashed);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      start = 1'b0;
      first = 1'b1;
      block = '0;
      test_reset();
      test_abc();
      test_empty();
      test_first_after_reset();
`ifdef SHA256_CHAIN_EN
      test_chain();
`else
      test_first_ignored();
`endif
      test_back_to_back();
      test_reset_abort();
      test_reset_priority();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
